even_counter: RTL and testbench



---
 rtl/even_counter.sv | 101 ++++++++++
 tb/tb_even_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/even_counter.sv
// even_counter
//   Free-running even-number counter. Advances by 2 on every rising clock edge
//   and wraps from MAX_EVEN (2^WIDTH - 2) back to 0. tc flags the cycle in
//   which count sits at MAX_EVEN so consumers can detect each wrap.
//
//   Optional build macro: EVEN_COUNTER_CHECK_EN
//     Adds a full-width shadow counter that runs alongside the main register.
//     Any disagreement with count, or an odd count, sets a sticky err flag on
//     the next clock edge. err clears only on reset. Without the macro, err
//     is tied to 0.
//
// Parameters
//   WIDTH  counter width in bits, legal range 2..16 (default 5)
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous reset, active-low (0 = held in reset)
//   count  out  WIDTH  current even count, registered
//   tc     out  1      high while count == MAX_EVEN
//   err    out  1      sticky integrity error (0 when check is compiled out)

module even_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_EVEN = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-2:0] CNT_ONE  = (WIDTH-1)'(1);

    // Only the upper WIDTH-1 bits are stored; the LSB is hard-wired to 0,
    // so an odd value cannot be produced by the counter itself.
    logic [WIDTH-2:0] cnt_q;
    logic [WIDTH-2:0] cnt_d;
    logic [WIDTH-1:0] count_full;

    // Carry out of the top bit is dropped, which gives the wrap to 0.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_full = {cnt_q, 1'b0};
    assign count      = count_full;
    assign tc         = (count_full == MAX_EVEN);

`ifdef EVEN_COUNTER_CHECK_EN

    localparam logic [WIDTH-1:0] SHADOW_STEP = WIDTH'(2);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic             err_q;
    logic             err_d;
    logic             mismatch;

    always_comb begin
        shadow_d = shadow_q + SHADOW_STEP;
        mismatch = (count_full != shadow_q) || count_full[0];
        err_d    = err_q | mismatch;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && mismatch) begin
            $error("even_counter: integrity error, count=%0d shadow=%0d",
                   count_full, shadow_q);
        end
    end
`endif

`else

    assign err = 1'b0;

`endif

endmodule

// File: tb/tb_even_counter.sv
module tb_even_counter;

    localparam int WIDTH = 5;

    logic             clk;
    logic             clk_en;
    logic             reset;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             err;

    int checks;
    int failures;

    even_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .tc    (tc),
        .err   (err)
    );

    // Gated clock so the stopped-clock scenario can park clk low.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 5'd0 || tc !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: count=%0d tc=%b err=%b expected 0/0/0",
                         count, tc, err);
            end
        end
    endtask

    task automatic test_release();
        logic [WIDTH-1:0] exp;
        exp = 5'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp = 5'(2 * i);
            checks++;
            if (count !== exp) begin
                failures++;
                $display("FAIL release_step%0d: count=%0d expected %0d", i, count, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp;
        logic             exp_tc;
        do_reset();
        exp = 5'd0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp    = (i == 16) ? 5'd0 : 5'(2 * i);
            exp_tc = (exp == 5'd30);
            checks++;
            if (count !== exp || tc !== exp_tc || count[0] !== 1'b0) begin
                failures++;
                $display("FAIL wrap_edge%0d: count=%0d tc=%b expected count=%0d tc=%b",
                         i, count, tc, exp, exp_tc);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (7) @(negedge clk);
        checks++;
        if (count !== 5'd14) begin
            failures++;
            $display("FAIL mid_pre: count=%0d expected 14", count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_clear: count=%0d tc=%b expected 0/0", count, tc);
        end
        #100;
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL mid_hold: count=%0d expected 0", count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 5'd2) begin
            failures++;
            $display("FAIL mid_restart: count=%0d expected 2", count);
        end
    endtask

    task automatic test_reset_at_max();
        do_reset();
        repeat (15) @(negedge clk);
        checks++;
        if (count !== 5'd30 || tc !== 1'b1) begin
            failures++;
            $display("FAIL max_pre: count=%0d tc=%b expected 30/1", count, tc);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL max_async_clear: count=%0d tc=%b expected 0/0", count, tc);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 5'd2) begin
            failures++;
            $display("FAIL max_restart: count=%0d expected 2", count);
        end
    endtask

    task automatic test_clock_stop();
        do_reset();
        repeat (11) @(negedge clk);
        checks++;
        if (count !== 5'd22) begin
            failures++;
            $display("FAIL stop_pre: count=%0d expected 22", count);
        end
        clk_en = 1'b0;
        #50;
        checks++;
        if (count !== 5'd22 || tc !== 1'b0) begin
            failures++;
            $display("FAIL stop_hold: count=%0d tc=%b expected 22/0", count, tc);
        end
        clk_en = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 5'd24) begin
            failures++;
            $display("FAIL stop_resume: count=%0d expected 24", count);
        end
    endtask

    task automatic test_back_to_back();
        // Short reset pulses between single edges: each restart must give 2.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            @(negedge clk);
            checks++;
            if (count !== 5'd2) begin
                failures++;
                $display("FAIL b2b_%0d: count=%0d expected 2", i, count);
            end
        end
    endtask

`ifdef EVEN_COUNTER_CHECK_EN
    task automatic test_check();
        do_reset();
        repeat (40) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL check_clean: err=%b expected 0", err);
        end
        force dut.count_full = 5'd3;
        @(negedge clk);
        release dut.count_full;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL check_set: err=%b expected 1", err);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL check_sticky: err=%b expected 1", err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL check_clear: err=%b expected 0", err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        clk_en   = 1'b1;
        reset    = 1'b0;

        test_reset();
        test_release();
        test_wrap();
        test_reset_mid();
        test_reset_at_max();
        test_clock_stop();
        test_back_to_back();
`ifdef EVEN_COUNTER_CHECK_EN
        test_check();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
